two_decimal_counter_ctrl: RTL and testbench
===========================================

Name: two_decimal_counter_ctrl

Overview:
Run/pause controller for the board's two-digit decimal display. It sequences a two-digit BCD up/down counter (00..99) from a prescaled tick and from pushbutton commands. One shared decoder_hex_10 instance is time-multiplexed between the two digits, with each digit's segment pattern held in a register. Top-level board block: switches and keys in, HEX1/HEX0/LEDR out.

Parameters:
TICK_DIV, 50_000_000, CLOCK_50 cycles per count step while running (min 2; benches use 4)
SYNC_STAGES, 2, synchroniser flops on KEY inputs (min 2)

Ports:
CLOCK_50  input  1  system clock, all logic rising-edge
RESET_N  input  1  asynchronous active-low reset (board KEY[0])
SW  input  10  [7:4] tens load value, [3:0] units load value, [8] direction (0 up, 1 down), [9] mode (0 wrap, 1 stop at limit)
KEY  input  3  active-low pushbuttons: [0]=board KEY1 run/pause toggle, [1]=KEY2 load, [2]=KEY3 single step
LEDR  output  10  [7:0] current count BCD, [8] running, [9] limit hold
HEX1  output  7  tens digit segments, active-low
HEX0  output  7  units digit segments, active-low

Behaviour:
- Reset (async assert, sync release): count=8'h00, state=IDLE, prescaler=0, sel=0, HEX1=HEX0=7'b1111111 (blank), LEDR=0, synchroniser flops=1 (released).
- KEY inputs pass through SYNC_STAGES flops. A falling edge of the synchronised value gives a one-cycle press pulse. A held key gives one pulse only.
- FSM states: IDLE, RUN, HOLD.
  - IDLE: toggle -> RUN. step -> apply one count step and stay in IDLE (HOLD if stop mode hits the limit).
  - RUN: toggle -> IDLE. Each tick applies one count step. In stop mode, a step that reaches 99 (up) or 00 (down) -> HOLD.
  - HOLD: toggle -> IDLE; no counting. A step is ignored.
  - Load in any state: count <= clamped SW[7:0], state <= IDLE, prescaler <= 0.
- Priority when pulses coincide in one cycle: load > toggle > step. Load also suppresses a tick in that cycle.
- Load clamp: each nibble >9 becomes 9 (SW=8'hA3 loads 8'h93).
- Prescaler: runs only in RUN. Counts 0..TICK_DIV-1; tick is asserted in the cycle the value is TICK_DIV-1, then the prescaler returns to 0. Cleared on entry to RUN and on load, so the first tick comes TICK_DIV cycles after entering RUN.
- Count step, BCD:
  - Up: units 9->0 with carry into tens. 99 -> 00 in wrap mode; in stop mode the count stays 99 and state -> HOLD.
  - Down: units 0->9 with borrow. 00 -> 99 in wrap mode; in stop mode the count stays 00 and state -> HOLD.
  - SW[8] and SW[9] are sampled at each step, not latched.
  - In stop mode, a step from 98 (up) reaches 99 and enters HOLD in the same cycle.
- Shared decoder:
  - sel toggles every cycle. The decoder input is the units nibble when sel=0, the tens nibble when sel=1.
  - The decoder output is registered into HEX0 (sel=0) or HEX1 (sel=1).
  - Any count change appears on both HEX outputs within 2 cycles of the count register update.
  - No glitch: each HEX register changes only on its own sel slot.
- LEDR is registered from count/state and updates 1 cycle after them. LEDR[8]=1 iff state==RUN; LEDR[9]=1 iff state==HOLD.
- Reset mid-count: all registers return to reset values immediately. After release, HEX shows "00" (7'b1000000 on both) within 2 cycles.

Test Plan:
- Reset, release, wait 3 cycles -> HEX1=HEX0=7'b1000000, LEDR=10'h000.
- SW=8'h47, SW[9:8]=00, pulse KEY[1] low -> LEDR[7:0]=8'h47, HEX1=4-pattern, HEX0=7-pattern within 3 cycles, state IDLE.
- TICK_DIV=4, load 8'h97, up, wrap, press toggle -> count 98, 99, 00 at 4-cycle intervals; LEDR[8]=1.
- Load 8'h01, down, stop mode, run -> 00 after one tick, LEDR[9]=1. Further ticks and step leave 00. Toggle -> IDLE, LEDR[9]=0.
- Load and toggle pulses in the same cycle while in RUN -> loaded value shown, LEDR[8]=0. Step in IDLE from 8'h09 up -> 8'h10. Load SW=8'hFC -> 8'h99.
- Assert RESET_N low mid-RUN at count 8'h35 -> HEX blank at once, count 00, IDLE. Key held low for 1000 cycles -> exactly one step.

Source files
------------

// File: rtl/two_decimal_counter_ctrl.sv
// rtl/two_decimal_counter_ctrl.sv - run/pause controller for a two-digit BCD up/down counter with multiplexed display
module decoder_hex_10 (
    input  logic [3:0] i_bcd,
    output logic [6:0] o_seg
);
    // Active-low segments, bit order gfedcba; non-decimal codes blank the digit
    always_comb begin
        o_seg = 7'b1111111;
        case (i_bcd)
            4'd0: o_seg = 7'b1000000;
            4'd1: o_seg = 7'b1111001;
            4'd2: o_seg = 7'b0100100;
            4'd3: o_seg = 7'b0110000;
            4'd4: o_seg = 7'b0011001;
            4'd5: o_seg = 7'b0010010;
            4'd6: o_seg = 7'b0000010;
            4'd7: o_seg = 7'b1111000;
            4'd8: o_seg = 7'b0000000;
            4'd9: o_seg = 7'b0010000;
            default: o_seg = 7'b1111111;
        endcase
    end
endmodule

module two_decimal_counter_ctrl #(
    parameter int TICK_DIV    = 50_000_000,
    parameter int SYNC_STAGES = 2
) (
    input  logic       CLOCK_50,
    input  logic       RESET_N,
    input  logic [9:0] SW,
    input  logic [2:0] KEY,
    output logic [9:0] LEDR,
    output logic [6:0] HEX1,
    output logic [6:0] HEX0
);
    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

    logic [SYNC_STAGES-1:0][2:0] r_sync;
    logic [2:0]                  r_key_d;
    logic [2:0]                  w_press;
    logic                        w_toggle, w_load, w_step;

    state_t      r_state, w_state_nxt;
    logic [7:0]  r_count, w_count_nxt;
    logic [PW-1:0] r_presc, w_presc_nxt;
    logic        w_tick;

    logic [3:0]  w_units, w_tens, w_tens_inc, w_tens_dec, w_units_inc, w_units_dec;
    logic [3:0]  w_ld_units, w_ld_tens;
    logic [7:0]  w_step_count;
    logic        w_step_hold;

    logic        r_sel;
    logic [3:0]  w_nib;
    logic [6:0]  w_seg;

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_sync  <= '1;
            r_key_d <= '1;
        end else begin
            r_sync  <= {r_sync[SYNC_STAGES-2:0], KEY};
            r_key_d <= r_sync[SYNC_STAGES-1];
        end
    end

    assign w_press  = r_key_d & ~r_sync[SYNC_STAGES-1];
    assign w_toggle = w_press[0];
    assign w_load   = w_press[1];
    assign w_step   = w_press[2];

    assign w_units     = r_count[3:0];
    assign w_tens      = r_count[7:4];
    assign w_tens_inc  = w_tens + 4'd1;
    assign w_tens_dec  = w_tens - 4'd1;
    assign w_units_inc = w_units + 4'd1;
    assign w_units_dec = w_units - 4'd1;
    assign w_ld_tens   = (SW[7:4] > 4'd9) ? 4'd9 : SW[7:4];
    assign w_ld_units  = (SW[3:0] > 4'd9) ? 4'd9 : SW[3:0];

    // In stop mode the limit value is sticky and reaching it requests HOLD
    always_comb begin
        w_step_count = r_count;
        w_step_hold  = 1'b0;
        if (!SW[8]) begin
            if (r_count == 8'h99)
                w_step_count = SW[9] ? 8'h99 : 8'h00;
            else if (w_units == 4'd9)
                w_step_count = {w_tens_inc, 4'd0};
            else
                w_step_count = {w_tens, w_units_inc};
            w_step_hold = SW[9] && (w_step_count == 8'h99);
        end else begin
            if (r_count == 8'h00)
                w_step_count = SW[9] ? 8'h00 : 8'h99;
            else if (w_units == 4'd0)
                w_step_count = {w_tens_dec, 4'd9};
            else
                w_step_count = {w_tens, w_units_dec};
            w_step_hold = SW[9] && (w_step_count == 8'h00);
        end
    end

    assign w_tick = (r_state == RUN) && (r_presc == PW'(TICK_DIV - 1));

    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_presc_nxt = '0;
        if (w_load) begin
            w_count_nxt = {w_ld_tens, w_ld_units};
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_toggle) begin
                        w_state_nxt = RUN;
                    end else if (w_step) begin
                        w_count_nxt = w_step_count;
                        if (w_step_hold)
                            w_state_nxt = HOLD;
                    end
                end
                RUN: begin
                    if (w_toggle) begin
                        w_state_nxt = IDLE;
                    end else begin
                        w_presc_nxt = w_tick ? '0 : r_presc + PW'(1);
                        if (w_tick) begin
                            w_count_nxt = w_step_count;
                            if (w_step_hold)
                                w_state_nxt = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (w_toggle)
                        w_state_nxt = IDLE;
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state <= IDLE;
            r_count <= 8'h00;
            r_presc <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            r_presc <= w_presc_nxt;
        end
    end

    assign w_nib = r_sel ? w_tens : w_units;

    decoder_hex_10 u_dec (
        .i_bcd (w_nib),
        .o_seg (w_seg)
    );

    // Each HEX register is written only in its own sel slot
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_sel <= 1'b0;
            HEX0  <= 7'b1111111;
            HEX1  <= 7'b1111111;
            LEDR  <= 10'h000;
        end else begin
            r_sel <= ~r_sel;
            if (r_sel)
                HEX1 <= w_seg;
            else
                HEX0 <= w_seg;
            LEDR <= {r_state == HOLD, r_state == RUN, r_count};
        end
    end
endmodule

// File: tb/tb_two_decimal_counter_ctrl.sv
// tb/tb_two_decimal_counter_ctrl.sv - directed self-checking bench for two_decimal_counter_ctrl
module tb_two_decimal_counter_ctrl;
    logic       CLOCK_50;
    logic       RESET_N;
    logic [9:0] SW;
    logic [2:0] KEY;
    logic [9:0] LEDR;
    logic [6:0] HEX1, HEX0;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [6:0] P0 = 7'b1000000, P4 = 7'b0011001, P7 = 7'b1111000,
                           P9 = 7'b0010000, BL = 7'b1111111;

    two_decimal_counter_ctrl #(.TICK_DIV(4), .SYNC_STAGES(2)) dut (
        .CLOCK_50 (CLOCK_50),
        .RESET_N  (RESET_N),
        .SW       (SW),
        .KEY      (KEY),
        .LEDR     (LEDR),
        .HEX1     (HEX1),
        .HEX0     (HEX0)
    );

    initial begin
        CLOCK_50 = 1'b0;
        forever #5 CLOCK_50 = ~CLOCK_50;
    end

    task automatic press(input int k, input int hold, input int post);
        @(posedge CLOCK_50); #1;
        KEY[k] = 1'b0;
        repeat (hold) @(posedge CLOCK_50);
        #1 KEY[k] = 1'b1;
        repeat (post) @(posedge CLOCK_50);
        @(negedge CLOCK_50);
    endtask

    task automatic do_load(input logic [9:0] sw);
        SW = sw;
        press(1, 2, 6);
    endtask

    task automatic wait_change(input logic [7:0] prev, output logic [7:0] val, output int cyc);
        cyc = 0;
        val = prev;
        while (cyc < 40 && val == prev) begin
            @(negedge CLOCK_50);
            cyc++;
            val = LEDR[7:0];
        end
    endtask

    task automatic test_reset;
        RESET_N = 1'b0;
        repeat (3) @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        n_cmp++; if (HEX1 !== BL || HEX0 !== BL) begin n_err++; $display("FAIL reset_blank: HEX1=%b HEX0=%b want %b", HEX1, HEX0, BL); end
        n_cmp++; if (LEDR !== 10'h000) begin n_err++; $display("FAIL reset_ledr: got %h want 000", LEDR); end
        @(posedge CLOCK_50); #1 RESET_N = 1'b1;
        repeat (3) @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        n_cmp++; if (HEX1 !== P0 || HEX0 !== P0) begin n_err++; $display("FAIL reset_zero: HEX1=%b HEX0=%b want %b", HEX1, HEX0, P0); end
        n_cmp++; if (LEDR !== 10'h000) begin n_err++; $display("FAIL reset_ledr_rel: got %h want 000", LEDR); end
    endtask

    task automatic test_load;
        do_load(10'h047);
        n_cmp++; if (LEDR !== 10'h047) begin n_err++; $display("FAIL load_ledr: got %h want 047", LEDR); end
        n_cmp++; if (HEX1 !== P4) begin n_err++; $display("FAIL load_hex1: got %b want %b", HEX1, P4); end
        n_cmp++; if (HEX0 !== P7) begin n_err++; $display("FAIL load_hex0: got %b want %b", HEX0, P7); end
    endtask

    task automatic test_run_wrap;
        logic [7:0] v;
        int c;
        do_load(10'h097);
        press(0, 1, 0);
        wait_change(8'h97, v, c);
        n_cmp++; if (v !== 8'h98) begin n_err++; $display("FAIL wrap_98: got %h want 98", v); end
        n_cmp++; if (LEDR[8] !== 1'b1) begin n_err++; $display("FAIL wrap_running: got %b want 1", LEDR[8]); end
        wait_change(8'h98, v, c);
        n_cmp++; if (v !== 8'h99 || c != 4) begin n_err++; $display("FAIL wrap_99: got %h after %0d want 99 after 4", v, c); end
        wait_change(8'h99, v, c);
        n_cmp++; if (v !== 8'h00 || c != 4) begin n_err++; $display("FAIL wrap_00: got %h after %0d want 00 after 4", v, c); end
        n_cmp++; if (LEDR[9:8] !== 2'b01) begin n_err++; $display("FAIL wrap_state: got %b want 01", LEDR[9:8]); end
        press(0, 1, 3);
        n_cmp++; if (LEDR[9:8] !== 2'b00) begin n_err++; $display("FAIL wrap_pause: got %b want 00", LEDR[9:8]); end
    endtask

    task automatic test_stop_down;
        logic [7:0] v;
        int c;
        do_load(10'h301);
        press(0, 1, 0);
        wait_change(8'h01, v, c);
        n_cmp++; if (v !== 8'h00) begin n_err++; $display("FAIL stop_00: got %h want 00", v); end
        n_cmp++; if (LEDR[9:8] !== 2'b10) begin n_err++; $display("FAIL stop_hold: got %b want 10", LEDR[9:8]); end
        repeat (12) @(posedge CLOCK_50);
        press(2, 1, 6);
        n_cmp++; if (LEDR !== 10'h200) begin n_err++; $display("FAIL stop_stays: got %h want 200", LEDR); end
        press(0, 1, 6);
        n_cmp++; if (LEDR !== 10'h000) begin n_err++; $display("FAIL stop_release: got %h want 000", LEDR); end
    endtask

    task automatic test_load_toggle;
        do_load(10'h000);
        press(0, 1, 6);
        n_cmp++; if (LEDR[8] !== 1'b1) begin n_err++; $display("FAIL lt_running: got %b want 1", LEDR[8]); end
        SW = 10'h055;
        @(posedge CLOCK_50); #1;
        KEY[1] = 1'b0; KEY[0] = 1'b0;
        repeat (2) @(posedge CLOCK_50);
        #1 KEY = 3'b111;
        repeat (10) @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        n_cmp++; if (LEDR !== 10'h055) begin n_err++; $display("FAIL lt_loaded: got %h want 055", LEDR); end
    endtask

    task automatic test_step_clamp;
        do_load(10'h009);
        press(2, 1, 6);
        n_cmp++; if (LEDR !== 10'h010) begin n_err++; $display("FAIL step_carry: got %h want 010", LEDR); end
        do_load(10'h0FC);
        n_cmp++; if (LEDR !== 10'h099) begin n_err++; $display("FAIL clamp_fc: got %h want 099", LEDR); end
        n_cmp++; if (HEX1 !== P9 || HEX0 !== P9) begin n_err++; $display("FAIL clamp_hex: HEX1=%b HEX0=%b want %b", HEX1, HEX0, P9); end
        do_load(10'h0A3);
        n_cmp++; if (LEDR !== 10'h093) begin n_err++; $display("FAIL clamp_a3: got %h want 093", LEDR); end
    endtask

    task automatic test_reset_mid;
        logic [7:0] v;
        int c;
        do_load(10'h034);
        press(0, 1, 0);
        wait_change(8'h34, v, c);
        n_cmp++; if (v !== 8'h35) begin n_err++; $display("FAIL mid_35: got %h want 35", v); end
        RESET_N = 1'b0;
        #1;
        n_cmp++; if (HEX1 !== BL || HEX0 !== BL || LEDR !== 10'h000) begin n_err++; $display("FAIL mid_reset: HEX1=%b HEX0=%b LEDR=%h want blank/000", HEX1, HEX0, LEDR); end
        @(posedge CLOCK_50); #1 RESET_N = 1'b1;
        repeat (3) @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        n_cmp++; if (HEX1 !== P0 || HEX0 !== P0 || LEDR !== 10'h000) begin n_err++; $display("FAIL mid_after: HEX1=%b HEX0=%b LEDR=%h want 00/000", HEX1, HEX0, LEDR); end
    endtask

    task automatic test_held_key;
        do_load(10'h010);
        press(2, 1000, 6);
        n_cmp++; if (LEDR !== 10'h011) begin n_err++; $display("FAIL held_one_step: got %h want 011", LEDR); end
    endtask

    initial begin
        RESET_N = 1'b0;
        SW      = 10'h000;
        KEY     = 3'b111;
        test_reset;
        test_load;
        test_run_wrap;
        test_stop_down;
        test_load_toggle;
        test_step_clamp;
        test_reset_mid;
        test_held_key;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
